// File: rtl/dmem_responder_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
// Loads return one word after a fixed number of wait states; stores are posted.
interface dmem_responder_if;
    logic        dmem_read_ready;
    logic [31:0] dmem_read_address;
    logic [31:0] dmem_read_data;
    logic        dmem_read_valid;
    logic        dmem_write_ready;
    logic [31:0] dmem_write_address;
    logic [31:0] dmem_write_data;
    logic [3:0]  dmem_write_byte;
    logic        dmem_write_valid;
    logic        dmem_busy;

    modport master (
        output dmem_read_ready, dmem_read_address,
        output dmem_write_ready, dmem_write_address, dmem_write_data, dmem_write_byte,
        input  dmem_read_data, dmem_read_valid, dmem_write_valid, dmem_busy
    );

    modport slave (
        input  dmem_read_ready, dmem_read_address,
        input  dmem_write_ready, dmem_write_address, dmem_write_data, dmem_write_byte,
        output dmem_read_data, dmem_read_valid, dmem_write_valid, dmem_busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled posted stores, word loads after WAIT_STATES+1 cycles.
// Optional DMEM_RAW_FWD_EN: a same-edge load sees the merged store data instead of the old word.
module dmem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  dmem
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            ld_accept;
    logic            resp_wait;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     hold;
    logic [31:0]     ld_word;
    logic [AW-1:0]   ridx;
    logic [AW-1:0]   widx;
    logic            unused_addr_bits;

    assign ridx = dmem.dmem_read_address[AW+1:2];
    assign widx = dmem.dmem_write_address[AW+1:2];
    assign unused_addr_bits = ^{dmem.dmem_read_address[31:AW+2], dmem.dmem_read_address[1:0],
                                dmem.dmem_write_address[31:AW+2], dmem.dmem_write_address[1:0]};

    always_comb begin
        ld_word = mem[ridx];
`ifdef DMEM_RAW_FWD_EN
        if (dmem.dmem_write_ready && (widx == ridx)) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem.dmem_write_byte[i]) begin
                    ld_word[8*i +: 8] = dmem.dmem_write_data[8*i +: 8];
                end
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld_accept = 1'b0;
        resp_wait = 1'b0;
        case (state)
            IDLE: begin
                if (dmem.dmem_read_ready) begin
                    ld_accept = 1'b1;
                    if (WAIT_STATES != 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                    resp_wait = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Zero wait states bypasses the hold register so loads can issue every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold                  <= 32'd0;
            dmem.dmem_read_data   <= 32'd0;
            dmem.dmem_read_valid  <= 1'b0;
            dmem.dmem_write_valid <= 1'b0;
        end else begin
            dmem.dmem_write_valid <= dmem.dmem_write_ready;
            dmem.dmem_read_valid  <= 1'b0;
            if (ld_accept) begin
                hold <= ld_word;
            end
            if (WAIT_STATES == 0) begin
                if (ld_accept) begin
                    dmem.dmem_read_valid <= 1'b1;
                    dmem.dmem_read_data  <= ld_word;
                end
            end else if (resp_wait) begin
                dmem.dmem_read_valid <= 1'b1;
                dmem.dmem_read_data  <= hold;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && dmem.dmem_write_ready) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem.dmem_write_byte[i]) begin
                    mem[widx][8*i +: 8] <= dmem.dmem_write_data[8*i +: 8];
                end
            end
        end
    end

    assign dmem.dmem_busy = (state == WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Three responders (0, 3 and 5 wait states) share one stimulus stream and one memory model.
module tb_dmem_responder;
    bit          clk = 1'b0;
    logic        rst;
    logic        rr, wr;
    logic [31:0] ra, wa, wd;
    logic [3:0]  wb;

    always #5 clk = ~clk;

    dmem_responder_if ifa ();
    dmem_responder_if ifb ();
    dmem_responder_if ifc ();

    assign ifa.dmem_read_ready = rr;  assign ifa.dmem_read_address = ra;
    assign ifa.dmem_write_ready = wr; assign ifa.dmem_write_address = wa;
    assign ifa.dmem_write_data = wd;  assign ifa.dmem_write_byte = wb;
    assign ifb.dmem_read_ready = rr;  assign ifb.dmem_read_address = ra;
    assign ifb.dmem_write_ready = wr; assign ifb.dmem_write_address = wa;
    assign ifb.dmem_write_data = wd;  assign ifb.dmem_write_byte = wb;
    assign ifc.dmem_read_ready = rr;  assign ifc.dmem_read_address = ra;
    assign ifc.dmem_write_ready = wr; assign ifc.dmem_write_address = wa;
    assign ifc.dmem_write_data = wd;  assign ifc.dmem_write_byte = wb;

    dmem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(0)) dut_a (.clk(clk), .reset(rst), .dmem(ifa));
    dmem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(3)) dut_b (.clk(clk), .reset(rst), .dmem(ifb));
    dmem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(5)) dut_c (.clk(clk), .reset(rst), .dmem(ifc));

    logic [31:0] o_rd [3];
    logic        o_rv [3];
    logic        o_wv [3];
    logic        o_bs [3];
    assign o_rd[0] = ifa.dmem_read_data;  assign o_rv[0] = ifa.dmem_read_valid;
    assign o_wv[0] = ifa.dmem_write_valid; assign o_bs[0] = ifa.dmem_busy;
    assign o_rd[1] = ifb.dmem_read_data;  assign o_rv[1] = ifb.dmem_read_valid;
    assign o_wv[1] = ifb.dmem_write_valid; assign o_bs[1] = ifb.dmem_busy;
    assign o_rd[2] = ifc.dmem_read_data;  assign o_rv[2] = ifc.dmem_read_valid;
    assign o_wv[2] = ifc.dmem_write_valid; assign o_bs[2] = ifc.dmem_busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: word array plus, per responder, the edge of its last accepted load.
    bit [31:0] mm [4096];
    int        ws [3] = '{0, 3, 5};
    int        last [3];
    bit [31:0] pend [3];
    bit [31:0] e_rd [3];
    bit        e_rv [3];
    bit        e_bs [3];
    bit        e_wv;
    int        cyc = 0;

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] be);
        bit [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int        ri = int'(ra[13:2]);
        int        wi = int'(wa[13:2]);
        bit [31:0] lw;
        if (rst) begin
            e_wv = 1'b0;
            for (int k = 0; k < 3; k++) begin
                last[k] = -1000; e_rd[k] = '0; e_rv[k] = 1'b0; e_bs[k] = 1'b0;
            end
            return;
        end
        lw = mm[ri];
`ifdef DMEM_RAW_FWD_EN
        if (wr && wi == ri) lw = merge(mm[ri], wd, wb);
`endif
        if (wr) mm[wi] = merge(mm[wi], wd, wb);
        e_wv = wr;
        for (int k = 0; k < 3; k++) begin
            if (rr && cyc >= last[k] + ws[k] + 1) begin
                last[k] = cyc;
                pend[k] = lw;
            end
            e_rv[k] = (cyc == last[k] + ws[k]);
            if (e_rv[k]) e_rd[k] = pend[k];
            e_bs[k] = (cyc >= last[k]) && (cyc < last[k] + ws[k]);
        end
    endtask

    task automatic step(input bit r);
        rst = r;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("read_valid[%0d]", k), 32'(o_rv[k]), 32'(e_rv[k]));
            chk($sformatf("busy[%0d]", k), 32'(o_bs[k]), 32'(e_bs[k]));
            chk($sformatf("write_valid[%0d]", k), 32'(o_wv[k]), 32'(e_wv));
            chk($sformatf("read_data[%0d]", k), o_rd[k], e_rd[k]);
        end
    endtask

    task automatic idle();
        rr = 1'b0; wr = 1'b0;
    endtask

    typedef struct {
        bit          rr;
        logic [31:0] ra;
        bit          wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  wb;
        bit          ev;
        bit          ew;
        logic [31:0] ed;
    } vec_t;

    initial begin
        vec_t        tbl [12];
        int          nb, nv, vs;
        logic [31:0] vd;
        logic [31:0] fwd_exp;
`ifdef DMEM_RAW_FWD_EN
        fwd_exp = 32'h1234_5655;
`else
        fwd_exp = 32'h1234_5678;
`endif
        tbl[0]  = '{0, 32'h0,    1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 1, 32'h0};
        tbl[1]  = '{1, 32'h10,   0, 32'h0,    32'h0,        4'h0, 1, 0, 32'hDEADBEEF};
        tbl[2]  = '{0, 32'h0,    1, 32'h20,   32'h11223344, 4'hF, 0, 1, 32'hDEADBEEF};
        tbl[3]  = '{0, 32'h0,    1, 32'h22,   32'hAABBCCDD, 4'h5, 0, 1, 32'hDEADBEEF};
        tbl[4]  = '{1, 32'h20,   0, 32'h0,    32'h0,        4'h0, 1, 0, 32'h11BB33DD};
        tbl[5]  = '{0, 32'h0,    1, 32'h30,   32'h12345678, 4'hF, 0, 1, 32'h11BB33DD};
        tbl[6]  = '{1, 32'h30,   1, 32'h30,   32'h00000055, 4'h1, 1, 1, fwd_exp};
        tbl[7]  = '{1, 32'h30,   1, 32'h8,    32'h01020304, 4'h0, 1, 1, 32'h12345655};
        tbl[8]  = '{0, 32'h0,    1, 32'h4004, 32'hCAFEF00D, 4'hF, 0, 1, 32'h12345655};
        tbl[9]  = '{1, 32'h4,    0, 32'h0,    32'h0,        4'h0, 1, 0, 32'hCAFEF00D};
        tbl[10] = '{1, 32'h10,   0, 32'h0,    32'h0,        4'h0, 1, 0, 32'hDEADBEEF};
        tbl[11] = '{0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 0, 32'hDEADBEEF};

        idle(); ra = '0; wa = '0; wd = '0; wb = '0;
        step(1); step(1);
        for (int k = 0; k < 3; k++) begin
            chk("reset_rd", o_rd[k], 32'h0);
            chk("reset_busy", 32'(o_bs[k]), 32'h0);
        end
        idle(); step(0);

        // Give every word the random traffic can reach a known value.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wa = 32'(i * 4); wd = $urandom; wb = 4'hF;
            step(0);
        end
        idle(); step(0);

        for (int i = 0; i < 12; i++) begin
            rr = tbl[i].rr; ra = tbl[i].ra; wr = tbl[i].wr;
            wa = tbl[i].wa; wd = tbl[i].wd; wb = tbl[i].wb;
            step(0);
            chk($sformatf("tbl%0d_rv", i), 32'(o_rv[0]), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_wv", i), 32'(o_wv[0]), 32'(tbl[i].ew));
            chk($sformatf("tbl%0d_rd", i), o_rd[0], tbl[i].ed);
        end
        idle();
        for (int i = 0; i < 8; i++) step(0);

        // WAIT_STATES=3: requests during busy are dropped, one response at +4.
        nb = 0; nv = 0; vs = -1; vd = '0;
        for (int s = 0; s < 8; s++) begin
            rr = (s <= 3); ra = (s == 0) ? 32'h10 : 32'h14;
            step(0);
            if (o_bs[1]) nb++;
            if (o_rv[1]) begin nv++; vs = s; vd = o_rd[1]; end
        end
        chk("ws3_busy_cycles", 32'(nb), 32'd3);
        chk("ws3_resp_count", 32'(nv), 32'd1);
        chk("ws3_resp_slot", 32'(vs), 32'd3);
        chk("ws3_resp_data", vd, 32'hDEADBEEF);
        idle();
        for (int i = 0; i < 4; i++) step(0);

        // WAIT_STATES=5: reset two cycles into a load drops it; store on reset edge is lost.
        nb = 0; nv = 0;
        for (int s = 0; s < 10; s++) begin
            rr = (s == 0); ra = 32'h10;
            wr = (s == 2); wa = 32'h10; wd = 32'h0BADF00D; wb = 4'hF;
            step(s == 2);
            if (o_rv[2]) nv++;
            if (s >= 2 && o_bs[2]) nb++;
        end
        chk("ws5_reset_resp", 32'(nv), 32'd0);
        chk("ws5_reset_busy", 32'(nb), 32'd0);
        nv = 0; vs = -1; vd = '0;
        for (int s = 0; s < 8; s++) begin
            rr = (s == 0); ra = 32'h10; wr = 1'b0;
            step(0);
            if (o_rv[2]) begin nv++; vs = s; vd = o_rd[2]; end
        end
        chk("ws5_fresh_count", 32'(nv), 32'd1);
        chk("ws5_fresh_slot", 32'(vs), 32'd5);
        chk("ws5_fresh_data", vd, 32'hDEADBEEF);

        for (int i = 0; i < 3000; i++) begin
            rr = 1'($urandom); wr = 1'($urandom);
            ra = $urandom & 32'hFFFF_C03F;
            wa = $urandom & 32'hFFFF_C03F;
            wd = $urandom; wb = 4'($urandom);
            step($urandom_range(0, 99) == 0);
        end
        idle();
        for (int i = 0; i < 8; i++) step(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
